// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: HD44780 init sequencer plus round-robin sharing of the LCD bus between two byte writers.
// Define LCD_FIXED_PRIO_EN to give requester 0 strict priority instead of round-robin.
module lcd_bus_arbiter #(
  parameter int SETUP_CYCLES      = 3,
  parameter int EN_HIGH_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000,
  parameter int INIT_WAIT_CYCLES  = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       LCD_ON,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic       busy,
  output logic       init_done
);
  localparam int MAX_A = SETUP_CYCLES > EN_HIGH_CYCLES ? SETUP_CYCLES : EN_HIGH_CYCLES;
  localparam int MAX_B = CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int MAX_C = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int MAX_W = MAX_C > INIT_WAIT_CYCLES ? MAX_C : INIT_WAIT_CYCLES;
  localparam int W = $clog2(MAX_W + 1);
  localparam logic [W-1:0] T_SETUP = W'(SETUP_CYCLES - 1);
  localparam logic [W-1:0] T_EN    = W'(EN_HIGH_CYCLES - 1);
  localparam logic [W-1:0] T_CMD   = W'(CMD_WAIT_CYCLES - 1);
  localparam logic [W-1:0] T_CLR   = W'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [W-1:0] T_INIT  = W'(INIT_WAIT_CYCLES - 1);
  typedef enum logic [2:0] {INIT_WAIT, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;
  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, term;
  logic [1:0]   idx_q, idx_d;
  logic         rs_q, rs_d, gnt_q, gnt_d, init_done_q, init_done_d;
  logic [7:0]   data_q, data_d;
  logic         last, is_clear, pick;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h01 : 8'h06;
  endfunction

  assign is_clear = !rs_q && data_q[7:2] == 6'd0 && data_q[1:0] != 2'd0;
  assign term = state_q == INIT_WAIT ? T_INIT :
                state_q == SETUP     ? T_SETUP :
                state_q == PULSE     ? T_EN :
                state_q == WAIT      ? (is_clear ? T_CLR : T_CMD) : '0;
  assign last = cnt_q == term;
`ifdef LCD_FIXED_PRIO_EN
  assign pick = !req0;
`else
  // gnt_q doubles as the round-robin pointer: it names the last requester served
  assign pick = (req0 && req1) ? !gnt_q : req1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = last ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    gnt_d       = gnt_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT_WAIT: if (last) begin
        state_d = SETUP;
        idx_d   = 2'd0;
        rs_d    = 1'b0;
        data_d  = init_byte(2'd0);
      end
      SETUP: if (last) state_d = PULSE;
      PULSE: if (last) state_d = HOLD;
      HOLD:  state_d = WAIT;
      WAIT: if (last) begin
        if (init_done_q) state_d = IDLE;
        else if (idx_q == 2'd3) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d = SETUP;
          idx_d   = idx_q + 2'd1;
          rs_d    = 1'b0;
          data_d  = init_byte(idx_q + 2'd1);
        end
      end
      IDLE: if (init_done_q && (req0 || req1)) begin
        state_d = SETUP;
        gnt_d   = pick;
        rs_d    = pick ? rs1 : rs0;
        data_d  = pick ? data1 : data0;
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= INIT_WAIT;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      gnt_q       <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      gnt_q       <= gnt_d;
      init_done_q <= init_done_d;
    end

  assign ack0      = state_q == WAIT && last && init_done_q && !gnt_q;
  assign ack1      = state_q == WAIT && last && init_done_q && gnt_q;
  assign LCD_ON    = 1'b1;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = state_q == PULSE;
  assign LCD_RS    = rs_q;
  assign LCD_DATA  = data_q;
  assign busy      = state_q != IDLE;
  assign init_done = init_done_q;
endmodule
